// File: rtl/upload_sequencer.sv
// upload_sequencer: read-enable sequencer for the dual-bank capture FIFO (rclk domain).
// Define UPLOAD_SEQ_INTERLEAVE_EN to alternate A/B word by word instead of block-sequential reads.
module upload_sequencer #(
    parameter int WORDS      = 16384,
    parameter int CNT_W      = 15,
    parameter int GAP_CYCLES = 4
) (
    input  logic             rclk,
    input  logic             _mr,
    input  logic             start,
    input  logic             abort,
    input  logic             empty_a,
    input  logic             empty_b,
    output logic             _renA,
    output logic             _renB,
    output logic             busy,
    output logic             done,
    output logic             bank_sel,
    output logic [CNT_W-1:0] word_cnt
);

`ifdef UPLOAD_SEQ_INTERLEAVE_EN
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_READ_A, S_GAP, S_READ_B, S_DONE} state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    logic [GAP_W-1:0] r_gap;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS);

    state_t           r_state;
    logic             r_ren_a;
    logic             r_ren_b;
    logic             r_busy;
    logic             r_done;
    logic             r_bank_sel;
    logic [CNT_W-1:0] r_cnt;

    logic             w_rd_a;
    logic             w_rd_b;
    logic [CNT_W-1:0] w_cnt_up;

    // A word is taken only on an edge where the enable was low and the bank had data.
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        w_rd_a = !r_ren_a && !empty_a;
        w_rd_b = !r_ren_b && !empty_b;
`ifdef UPLOAD_SEQ_INTERLEAVE_EN
        w_cnt_up = r_cnt + CNT_W'(w_rd_b);
`else
        w_cnt_up = r_cnt + CNT_W'(w_rd_a | w_rd_b);
`endif
    end

    assign _renA    = r_ren_a;
    assign _renB    = r_ren_b;
    assign busy     = r_busy;
    assign done     = r_done;
    assign bank_sel = r_bank_sel;
    assign word_cnt = r_cnt;

`ifdef UPLOAD_SEQ_INTERLEAVE_EN
    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge rclk or negedge _mr) begin
        if (!_mr) begin
            r_state    <= S_IDLE;
            r_ren_a    <= 1'b1;
            r_ren_b    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bank_sel <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_ren_a <= 1'b1;
                r_ren_b <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_state    <= S_READ;
                            r_busy     <= 1'b1;
                            r_bank_sel <= 1'b0;
                            r_cnt      <= '0;
                            r_ren_a    <= empty_a;
                            r_ren_b    <= 1'b1;
                        end
                    end
                    S_READ: begin
                        if (w_rd_a || w_rd_b) begin
                            r_bank_sel <= !r_bank_sel;
                            r_cnt      <= w_cnt_up;
                            if (w_rd_b && w_cnt_up == LAST) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_ren_a <= 1'b1;
                                r_ren_b <= 1'b1;
                            end else begin
                                // Hand over to the other bank; it waits if that bank is empty.
                                r_ren_a <= r_bank_sel ? empty_a : 1'b1;
                                r_ren_b <= r_bank_sel ? 1'b1 : empty_b;
                            end
                        end else begin
                            r_ren_a <= r_bank_sel ? 1'b1 : empty_a;
                            r_ren_b <= r_bank_sel ? empty_b : 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ren_a <= 1'b1;
                        r_ren_b <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
`else
    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge rclk or negedge _mr) begin
        if (!_mr) begin
            r_state    <= S_IDLE;
            r_ren_a    <= 1'b1;
            r_ren_b    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bank_sel <= 1'b0;
            r_cnt      <= '0;
            r_gap      <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_ren_a <= 1'b1;
                r_ren_b <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_state    <= S_READ_A;
                            r_busy     <= 1'b1;
                            r_bank_sel <= 1'b0;
                            r_cnt      <= '0;
                            r_ren_a    <= empty_a;
                        end
                    end
                    S_READ_A: begin
                        if (w_cnt_up == LAST) begin
                            r_cnt      <= '0;
                            r_bank_sel <= 1'b1;
                            r_ren_a    <= 1'b1;
                            r_gap      <= '0;
                            if (GAP_CYCLES == 0) begin
                                r_state <= S_READ_B;
                                r_ren_b <= empty_b;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end else begin
                            r_cnt   <= w_cnt_up;
                            r_ren_a <= empty_a;
                        end
                    end
                    S_GAP: begin
                        if (r_gap == GAP_LAST) begin
                            r_state <= S_READ_B;
                            r_ren_b <= empty_b;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    S_READ_B: begin
                        r_cnt <= w_cnt_up;
                        if (w_cnt_up == LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_ren_b <= 1'b1;
                        end else begin
                            r_ren_b <= empty_b;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ren_a <= 1'b1;
                        r_ren_b <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
`endif

endmodule
